// File: rtl/control_unit_multi.sv
// control_unit_multi
//   Byte-stream command decoder and pipeline bank manager. Commands arrive one
//   byte at a time, each followed by an XOR checksum byte. Valid commands
//   produce one-cycle strobes to the pipeline banks. The unit also rotates the
//   front/back banks (program, swap, reset) and runs a watchdog.
// Ports
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_byte, in_valid, next : byte input; next pulses when a byte is consumed
//   block_target, reg_target, instr_out, data_out,
//   delay_size_out, init_delay_out : payload data, held after each strobe
//   block_instr_write, block_reg_write, reg_writes_commit, alloc_delay,
//   pipeline_full_reset     : one-hot per-bank strobes
//   pipeline_enables        : per-bank enable levels
//   pipeline_resetting, pipeline_regfiles_syncing, pipelines_swapping : bank status
//   swap_pipelines, front_pipeline, back_pipeline : bank rotation
//   set_input_gain, set_output_gain, invalid, checksum_error, timeout_pulse : pulses
//   control_state           : status byte
module control_unit_multi #(
    parameter int unsigned N_BLOCKS       = 256,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned N_PIPELINES    = 2,
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    localparam int unsigned BLK_W  = $clog2(N_BLOCKS),
    localparam int unsigned PIPE_W = $clog2(N_PIPELINES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [7:0]               in_byte,
    input  logic                     in_valid,
    output logic                     next,
    output logic [BLK_W-1:0]         block_target,
    output logic                     reg_target,
    output logic [INSTR_WIDTH-1:0]   instr_out,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [2*DATA_WIDTH-1:0]  delay_size_out,
    output logic [2*DATA_WIDTH-1:0]  init_delay_out,
    output logic [N_PIPELINES-1:0]   block_instr_write,
    output logic [N_PIPELINES-1:0]   block_reg_write,
    output logic [N_PIPELINES-1:0]   reg_writes_commit,
    output logic [N_PIPELINES-1:0]   alloc_delay,
    output logic [N_PIPELINES-1:0]   pipeline_full_reset,
    output logic [N_PIPELINES-1:0]   pipeline_enables,
    input  logic [N_PIPELINES-1:0]   pipeline_resetting,
    input  logic [N_PIPELINES-1:0]   pipeline_regfiles_syncing,
    output logic                     swap_pipelines,
    input  logic                     pipelines_swapping,
    output logic [PIPE_W-1:0]        front_pipeline,
    output logic [PIPE_W-1:0]        back_pipeline,
    output logic                     set_input_gain,
    output logic                     set_output_gain,
    output logic                     invalid,
    output logic                     checksum_error,
    output logic                     timeout_pulse,
    output logic [7:0]               control_state
);
    localparam logic [7:0] CMD_BEGIN_PROGRAM      = 8'h01;
    localparam logic [7:0] CMD_END_PROGRAM        = 8'h02;
    localparam logic [7:0] CMD_COMMIT_REG_UPDATES = 8'h03;
    localparam logic [7:0] CMD_WRITE_BLOCK_INSTR  = 8'h10;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG_0  = 8'h11;
    localparam logic [7:0] CMD_WRITE_BLOCK_REG_1  = 8'h12;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG_0 = 8'h13;
    localparam logic [7:0] CMD_UPDATE_BLOCK_REG_1 = 8'h14;
    localparam logic [7:0] CMD_ALLOC_DELAY        = 8'h15;
    localparam logic [7:0] CMD_SET_INPUT_GAIN     = 8'h16;
    localparam logic [7:0] CMD_SET_OUTPUT_GAIN    = 8'h17;

    localparam int unsigned ADDR_BYTES = (N_BLOCKS > 256) ? 2 : 1;
    localparam int unsigned DATA_BYTES = DATA_WIDTH / 8;
    localparam int unsigned LEN_INSTR  = ADDR_BYTES + INSTR_WIDTH / 8;
    localparam int unsigned LEN_REG    = ADDR_BYTES + DATA_BYTES;
    localparam int unsigned LEN_ALLOC  = 6;
    localparam int unsigned PAY_MAX    = (LEN_INSTR > LEN_REG) ?
                                         ((LEN_INSTR > LEN_ALLOC) ? LEN_INSTR : LEN_ALLOC) :
                                         ((LEN_REG > LEN_ALLOC) ? LEN_REG : LEN_ALLOC);
    localparam int unsigned SH_W  = PAY_MAX * 8;
    localparam int unsigned CNT_W = $clog2(PAY_MAX + 1);
    localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_READY      = 3'd0,
        S_LISTEN     = 3'd1,
        S_CHECK      = 3'd2,
        S_EXECUTE    = 3'd3,
        S_SWAP_WAIT  = 3'd4,
        S_RESET_WAIT = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic                    guard_q, next_q, prog_q, prog_d, chk_ok_q, chk_ok_d;
    logic [7:0]              cmd_q, cmd_d, xor_q, xor_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SH_W-1:0]         sh_q, sh_d;
    logic [PIPE_W-1:0]       front_q, front_d, back, tgt;
    logic [N_PIPELINES-1:0]  en_q, en_d, biw_q, biw_d, brw_q, brw_d, rwc_q, rwc_d;
    logic [N_PIPELINES-1:0]  ad_q, ad_d, pfr_q, pfr_d;
    logic                    swap_q, swap_d, sin_q, sin_d, sout_q, sout_d;
    logic                    inv_q, inv_d, cerr_q, cerr_d, tmo_q, tmo_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic                    regt_q, regt_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [2*DATA_WIDTH-1:0] dsize_q, dsize_d, dinit_q, dinit_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [3:0]              stretch_q, stretch_d;
    logic                    counting, timeout, accept, is_update, stall;

    function automatic logic [N_PIPELINES-1:0] bank_oh(input logic [PIPE_W-1:0] b);
        return N_PIPELINES'(1) << b;
    endfunction

    function automatic logic [CNT_W-1:0] payload_len(input logic [7:0] c);
        case (c)
            CMD_WRITE_BLOCK_INSTR:                        return CNT_W'(LEN_INSTR);
            CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1,
            CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1: return CNT_W'(LEN_REG);
            CMD_ALLOC_DELAY:                              return CNT_W'(LEN_ALLOC);
            CMD_SET_INPUT_GAIN, CMD_SET_OUTPUT_GAIN:      return CNT_W'(DATA_BYTES);
            default:                                      return '0;
        endcase
    endfunction

    assign back      = (front_q == PIPE_W'(N_PIPELINES - 1)) ? '0 : front_q + 1'b1;
    assign counting  = prog_q || (state_q != S_READY);
    assign timeout   = counting && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    // Timeout wins over a byte arriving in the same cycle, so the byte is left unconsumed.
    assign accept    = in_valid && !guard_q && !timeout &&
                       ((state_q == S_READY) || (state_q == S_LISTEN));
    assign is_update = (cmd_q == CMD_UPDATE_BLOCK_REG_0) || (cmd_q == CMD_UPDATE_BLOCK_REG_1);
    assign tgt       = is_update ? front_q : back;
    assign stall     = pipelines_swapping ||
                       ((pipeline_resetting | pipeline_regfiles_syncing) & bank_oh(tgt)) != '0;

    always_comb begin
        state_d = state_q;   prog_d  = prog_q;   cmd_d   = cmd_q;   cnt_d   = cnt_q;
        xor_d   = xor_q;     chk_ok_d = chk_ok_q; sh_d   = sh_q;    front_d = front_q;
        en_d    = en_q;      biw_d   = '0;       brw_d   = '0;      rwc_d   = '0;
        ad_d    = '0;        pfr_d   = '0;       swap_d  = 1'b0;    sin_d   = 1'b0;
        sout_d  = 1'b0;      inv_d   = 1'b0;     cerr_d  = 1'b0;    tmo_d   = 1'b0;
        blk_d   = blk_q;     regt_d  = regt_q;   instr_d = instr_q; data_d  = data_q;
        dsize_d = dsize_q;   dinit_d = dinit_q;
        if (timeout) begin
            tmo_d   = 1'b1;
            pfr_d   = bank_oh(back);
            prog_d  = 1'b0;
            state_d = S_RESET_WAIT;
        end else begin
            case (state_q)
                S_READY: if (accept) begin
                    case (in_byte)
                        CMD_BEGIN_PROGRAM:      prog_d = 1'b1;
                        CMD_COMMIT_REG_UPDATES: rwc_d  = bank_oh(front_q);
                        CMD_END_PROGRAM: if (prog_q) begin
                            swap_d  = 1'b1;
                            rwc_d   = bank_oh(back);
                            en_d    = en_q | bank_oh(back);
                            prog_d  = 1'b0;
                            state_d = S_SWAP_WAIT;
                        end
                        default: if (payload_len(in_byte) != '0) begin
                            cmd_d   = in_byte;
                            cnt_d   = payload_len(in_byte);
                            xor_d   = in_byte;
                            sh_d    = '0;
                            state_d = S_LISTEN;
                        end else begin
                            inv_d = 1'b1;
                        end
                    endcase
                end
                S_LISTEN: if (accept) begin
                    if (cnt_q != '0) begin
                        sh_d  = {sh_q[SH_W-9:0], in_byte};
                        xor_d = xor_q ^ in_byte;
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        chk_ok_d = (in_byte == xor_q);
                        state_d  = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!chk_ok_q) begin
                        cerr_d  = 1'b1;
                        state_d = S_READY;
                    end else if (!prog_q && ((cmd_q == CMD_WRITE_BLOCK_INSTR) ||
                                             (cmd_q == CMD_WRITE_BLOCK_REG_0) ||
                                             (cmd_q == CMD_WRITE_BLOCK_REG_1) ||
                                             (cmd_q == CMD_ALLOC_DELAY))) begin
                        state_d = S_READY;
                    end else begin
                        state_d = S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    state_d = S_READY;
                    case (cmd_q)
                        CMD_WRITE_BLOCK_INSTR: begin
                            biw_d   = bank_oh(back);
                            blk_d   = sh_q[INSTR_WIDTH +: BLK_W];
                            instr_d = sh_q[INSTR_WIDTH-1:0];
                        end
                        CMD_WRITE_BLOCK_REG_0, CMD_WRITE_BLOCK_REG_1,
                        CMD_UPDATE_BLOCK_REG_0, CMD_UPDATE_BLOCK_REG_1: begin
                            // An update racing a swap would land in a bank about to change role.
                            if (is_update && pipelines_swapping) begin
                                state_d = S_READY;
                            end else if (stall) begin
                                state_d = S_EXECUTE;
                            end else begin
                                brw_d  = bank_oh(tgt);
                                regt_d = (cmd_q == CMD_WRITE_BLOCK_REG_1) ||
                                         (cmd_q == CMD_UPDATE_BLOCK_REG_1);
                                blk_d  = sh_q[DATA_WIDTH +: BLK_W];
                                data_d = sh_q[DATA_WIDTH-1:0];
                            end
                        end
                        CMD_ALLOC_DELAY: begin
                            ad_d    = bank_oh(back);
                            dsize_d = {{(2*DATA_WIDTH-24){1'b0}}, sh_q[47:24]};
                            dinit_d = {{(2*DATA_WIDTH-24){1'b0}}, sh_q[23:0]};
                        end
                        CMD_SET_INPUT_GAIN: begin
                            sin_d  = 1'b1;
                            data_d = sh_q[DATA_WIDTH-1:0];
                        end
                        CMD_SET_OUTPUT_GAIN: begin
                            sout_d = 1'b1;
                            data_d = sh_q[DATA_WIDTH-1:0];
                        end
                        default: state_d = S_READY;
                    endcase
                end
                S_SWAP_WAIT: if (!pipelines_swapping && !guard_q) begin
                    front_d = back;
                    pfr_d   = bank_oh(front_q);
                    en_d    = en_q & ~bank_oh(front_q);
                    state_d = S_RESET_WAIT;
                end
                S_RESET_WAIT: if (!guard_q && (pipeline_resetting == '0)) begin
                    en_d    = bank_oh(front_q);
                    state_d = S_READY;
                end
                default: state_d = S_READY;
            endcase
        end
    end

    assign wd_d      = (!counting || accept || timeout || (state_d != state_q)) ? '0 : wd_q + 1'b1;
    assign stretch_d = timeout ? '1 : ((stretch_q != '0) ? stretch_q - 1'b1 : '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET_WAIT; guard_q <= 1'b1; next_q <= 1'b0; prog_q <= 1'b0;
            chk_ok_q <= 1'b0; cmd_q <= '0; xor_q <= '0; cnt_q <= '0; sh_q <= '0;
            front_q <= '0; en_q <= '0; biw_q <= '0; brw_q <= '0; rwc_q <= '0;
            ad_q <= '0; pfr_q <= '1; swap_q <= 1'b0; sin_q <= 1'b0; sout_q <= 1'b0;
            inv_q <= 1'b0; cerr_q <= 1'b0; tmo_q <= 1'b0; blk_q <= '0; regt_q <= 1'b0;
            instr_q <= '0; data_q <= '0; dsize_q <= '0; dinit_q <= '0;
            wd_q <= '0; stretch_q <= '0;
        end else begin
            state_q <= state_d; guard_q <= accept; next_q <= accept; prog_q <= prog_d;
            chk_ok_q <= chk_ok_d; cmd_q <= cmd_d; xor_q <= xor_d; cnt_q <= cnt_d; sh_q <= sh_d;
            front_q <= front_d; en_q <= en_d; biw_q <= biw_d; brw_q <= brw_d; rwc_q <= rwc_d;
            ad_q <= ad_d; pfr_q <= pfr_d; swap_q <= swap_d; sin_q <= sin_d; sout_q <= sout_d;
            inv_q <= inv_d; cerr_q <= cerr_d; tmo_q <= tmo_d; blk_q <= blk_d; regt_q <= regt_d;
            instr_q <= instr_d; data_q <= data_d; dsize_q <= dsize_d; dinit_q <= dinit_d;
            wd_q <= wd_d; stretch_q <= stretch_d;
        end
    end

    assign next                = next_q;
    assign block_target        = blk_q;
    assign reg_target          = regt_q;
    assign instr_out           = instr_q;
    assign data_out            = data_q;
    assign delay_size_out      = dsize_q;
    assign init_delay_out      = dinit_q;
    assign block_instr_write   = biw_q;
    assign block_reg_write     = brw_q;
    assign reg_writes_commit   = rwc_q;
    assign alloc_delay         = ad_q;
    assign pipeline_full_reset = pfr_q;
    assign pipeline_enables    = en_q;
    assign swap_pipelines      = swap_q;
    assign front_pipeline      = front_q;
    assign back_pipeline       = back;
    assign set_input_gain      = sin_q;
    assign set_output_gain     = sout_q;
    assign invalid             = inv_q;
    assign checksum_error      = cerr_q;
    assign timeout_pulse       = tmo_q;
    assign control_state       = {2'b00, stretch_q != '0, counting, prog_q, state_q};
endmodule

// File: tb/tb_control_unit_multi.sv
module tb_control_unit_multi;
    localparam int unsigned NP = 4;
    localparam int unsigned TO = 100;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        next;
    logic [7:0]  block_target;
    logic        reg_target;
    logic [31:0] instr_out;
    logic [15:0] data_out;
    logic [31:0] delay_size_out, init_delay_out;
    logic [3:0]  block_instr_write, block_reg_write, reg_writes_commit, alloc_delay;
    logic [3:0]  pipeline_full_reset, pipeline_enables;
    logic [3:0]  pipeline_resetting, pipeline_regfiles_syncing;
    logic        swap_pipelines, pipelines_swapping;
    logic [1:0]  front_pipeline, back_pipeline;
    logic        set_input_gain, set_output_gain, invalid, checksum_error, timeout_pulse;
    logic [7:0]  control_state;

    always #5 clk = ~clk;

    control_unit_multi #(
        .N_BLOCKS(256), .DATA_WIDTH(16), .N_PIPELINES(NP),
        .INSTR_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_byte(in_byte), .in_valid(in_valid), .next(next),
        .block_target(block_target), .reg_target(reg_target), .instr_out(instr_out),
        .data_out(data_out), .delay_size_out(delay_size_out), .init_delay_out(init_delay_out),
        .block_instr_write(block_instr_write), .block_reg_write(block_reg_write),
        .reg_writes_commit(reg_writes_commit), .alloc_delay(alloc_delay),
        .pipeline_full_reset(pipeline_full_reset), .pipeline_enables(pipeline_enables),
        .pipeline_resetting(pipeline_resetting),
        .pipeline_regfiles_syncing(pipeline_regfiles_syncing),
        .swap_pipelines(swap_pipelines), .pipelines_swapping(pipelines_swapping),
        .front_pipeline(front_pipeline), .back_pipeline(back_pipeline),
        .set_input_gain(set_input_gain), .set_output_gain(set_output_gain),
        .invalid(invalid), .checksum_error(checksum_error), .timeout_pulse(timeout_pulse),
        .control_state(control_state)
    );

    typedef struct packed {
        logic [25:0] s;
        logic [63:0] d;
    } ev_t;

    localparam logic [5:0] F_NONE = 6'b000000, F_SWAP = 6'b100000, F_SIN = 6'b010000,
                           F_SOUT = 6'b001000, F_INV = 6'b000100, F_CERR = 6'b000010,
                           F_TMO  = 6'b000001;

    ev_t         exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          mon_en   = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [25:0] sv(input logic [3:0] biw, input logic [3:0] brw,
                                       input logic [3:0] rwc, input logic [3:0] ad,
                                       input logic [3:0] pfr, input logic [5:0] fl);
        return {biw, brw, rwc, ad, pfr, fl};
    endfunction

    function automatic logic [3:0] oh(input int unsigned b);
        return 4'(1 << b);
    endfunction

    task automatic expect_ev(input logic [25:0] s, input logic [63:0] d);
        ev_t e;
        e.s = s;
        e.d = d;
        exp_q.push_back(e);
    endtask

    function automatic logic [63:0] obs_data();
        if (block_reg_write != '0)   return {39'b0, reg_target, block_target, data_out};
        if (block_instr_write != '0) return {24'b0, block_target, instr_out};
        if (alloc_delay != '0)       return {delay_size_out, init_delay_out};
        if (set_input_gain || set_output_gain) return {48'b0, data_out};
        return 64'b0;
    endfunction

    // Monitor: any strobe activity is matched against the next expected event.
    always @(negedge clk) begin
        ev_t o, e;
        if (mon_en) begin
            o.s = {block_instr_write, block_reg_write, reg_writes_commit, alloc_delay,
                   pipeline_full_reset, swap_pipelines, set_input_gain, set_output_gain,
                   invalid, checksum_error, timeout_pulse};
            o.d = obs_data();
            if (o.s != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {38'b0, o.s}, 64'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("strobes", {38'b0, o.s}, {38'b0, e.s});
                    check("strobe_data", o.d, e.d);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int unsigned n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            if (next) break;
            n++;
            if (n > 50) begin
                check("byte_accept", 64'(next), 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [63:0] msg, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) send_byte(msg[(n-1-i)*8 +: 8]);
    endtask

    task automatic wait_ready(input string nm);
        int unsigned n = 0;
        while (control_state[2:0] != 3'd0) begin
            @(posedge clk); #1;
            n++;
            if (n > 300) begin
                check(nm, 64'(control_state[2:0]), 64'd0);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int unsigned early, n, fr, nb;
        reset_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
        pipeline_resetting = '0; pipeline_regfiles_syncing = '0; pipelines_swapping = 1'b0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_full_reset", 64'(pipeline_full_reset), 64'hF);
        check("rst_enables", 64'(pipeline_enables), 64'h0);
        check("rst_front", 64'(front_pipeline), 64'd0);
        check("rst_state", 64'(control_state[2:0]), 64'd5);
        check("rst_programming", 64'(control_state[3]), 64'd0);
        check("rst_next", 64'(next), 64'd0);
        check("rst_reg_write", 64'(block_reg_write), 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel_full_reset_clear", 64'(pipeline_full_reset), 64'h0);
        check("rel_enables_pending", 64'(pipeline_enables), 64'h0);
        @(posedge clk); #1;
        check("rel_enables", 64'(pipeline_enables), 64'b0001);
        check("rel_front", 64'(front_pipeline), 64'd0);
        check("rel_back", 64'(back_pipeline), 64'd1);
        check("rel_state", 64'(control_state[2:0]), 64'd0);
        mon_en = 1'b1;

        // Program: reg write to back bank, then swap
        send_msg(64'h01, 1);
        check("begin_programming", 64'(control_state[3]), 64'd1);
        expect_ev(sv(4'b0, 4'b0010, 4'b0, 4'b0, 4'b0, F_NONE), 64'h0000_0000_0112_BEEF);
        send_msg(64'h1212BEEF51, 5);
        wait_ready("wreg_ready");
        expect_ev(sv(4'b0, 4'b0, 4'b0010, 4'b0, 4'b0, F_SWAP), 64'h0);
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0001, F_NONE), 64'h0);
        send_msg(64'h02, 1);
        wait_ready("swap1_ready");
        check("swap1_front", 64'(front_pipeline), 64'd1);
        check("swap1_back", 64'(back_pipeline), 64'd2);
        check("swap1_enables", 64'(pipeline_enables), 64'b0010);
        check("swap1_programming", 64'(control_state[3]), 64'd0);

        // Bad checksum, instr write, alloc, gains, swap
        send_msg(64'h01, 1);
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, F_CERR), 64'h0);
        send_msg(64'h1212BEEF50, 5);
        wait_ready("cerr_ready");
        expect_ev(sv(4'b0100, 4'b0, 4'b0, 4'b0, 4'b0, F_NONE), 64'h0000_0005_DEAD_BEEF);
        send_msg(64'h1005DEADBEEF37, 7);
        wait_ready("instr_ready");
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0100, 4'b0, F_NONE), 64'h0000_0100_0000_0020);
        send_msg(64'h1500010000002034, 8);
        wait_ready("alloc_ready");
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, F_SIN), 64'h1234);
        send_msg(64'h16123430, 4);
        wait_ready("gin_ready");
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, F_SOUT), 64'hA55A);
        send_msg(64'h17A55AE8, 4);
        wait_ready("gout_ready");
        expect_ev(sv(4'b0, 4'b0, 4'b0100, 4'b0, 4'b0, F_SWAP), 64'h0);
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0010, F_NONE), 64'h0);
        send_msg(64'h02, 1);
        wait_ready("swap2_ready");
        check("swap2_front", 64'(front_pipeline), 64'd2);
        check("swap2_enables", 64'(pipeline_enables), 64'b0100);

        // Update stalled by regfile sync on the front bank
        pipeline_regfiles_syncing = 4'b0100;
        expect_ev(sv(4'b0, 4'b0100, 4'b0, 4'b0, 4'b0, F_NONE), 64'h0000_0000_0007_0A0B);
        send_msg(64'h13070A0B15, 5);
        early = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (block_reg_write != '0) early++;
        end
        check("stall_no_early_strobe", 64'(early), 64'd0);
        pipeline_regfiles_syncing = '0;
        @(posedge clk); #1;
        check("stall_release_strobe", 64'(block_reg_write), 64'b0100);
        wait_ready("stall_ready");

        // Update during swapping is dropped
        pipelines_swapping = 1'b1;
        send_msg(64'h14070A0B12, 5);
        wait_ready("drop_ready");
        repeat (3) @(posedge clk);
        #1;
        pipelines_swapping = 1'b0;

        // Commit, invalid, END without BEGIN, write without BEGIN
        expect_ev(sv(4'b0, 4'b0, 4'b0100, 4'b0, 4'b0, F_NONE), 64'h0);
        send_msg(64'h03, 1);
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b0, F_INV), 64'h0);
        send_msg(64'hFF, 1);
        send_msg(64'h02, 1);
        repeat (3) @(posedge clk);
        #1;
        check("end_ignored_state", 64'(control_state[2:0]), 64'd0);
        check("end_ignored_front", 64'(front_pipeline), 64'd2);
        send_msg(64'h1101000212, 5);
        wait_ready("nowrite_ready");
        repeat (4) @(posedge clk);
        #1;
        check("pending_before_timeout", 64'(exp_q.size()), 64'd0);

        // Watchdog: BEGIN then idle
        expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, 4'b1000, F_TMO), 64'h0);
        send_msg(64'h01, 1);
        n = 0;
        while (!timeout_pulse && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_cycle", 64'(n), 64'(TO));
        check("timeout_programming", 64'(control_state[3]), 64'd0);
        check("timeout_state", 64'(control_state[2:0]), 64'd5);
        check("timeout_stretch", 64'(control_state[5]), 64'd1);
        wait_ready("timeout_ready");
        check("timeout_enables", 64'(pipeline_enables), 64'b0100);

        // Four rotations, wrapping past bank 3
        fr = 2;
        for (int i = 0; i < 4; i++) begin
            nb = (fr + 1) % NP;
            expect_ev(sv(4'b0, 4'b0, oh(nb), 4'b0, 4'b0, F_SWAP), 64'h0);
            expect_ev(sv(4'b0, 4'b0, 4'b0, 4'b0, oh(fr), F_NONE), 64'h0);
            send_msg(64'h01, 1);
            send_msg(64'h02, 1);
            wait_ready("rot_ready");
            fr = nb;
            check("rot_front", 64'(front_pipeline), 64'(fr));
            check("rot_enables", 64'(pipeline_enables), 64'(oh(fr)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
